bp_cce_ucode_loader: RTL and testbench

- Config-bus master for the CCE microcode interface: the writer/initiator end of the ucode write/read fields that the CCE instruction RAM consumes.
- Accepts a ready/valid stream of CCE instructions, writes them to instruction RAM addresses 0..N-1, then reads them back and checks an XOR checksum.
- On success, switches cce_mode from uncached to normal, which releases the CCE PC to fetch from address 0.
- Sits in the tile config logic beside the cfg bus register; its outputs merge into the cfg bus ucode and mode fields.

---
 rtl/bp_cce_pkg.sv | 9 +
 rtl/bp_cce_ucode_loader_pkg.sv | 9 +
 rtl/bsg_counter_clear_up.sv | 27 ++
 rtl/bp_cce_ucode_loader.sv | 132 +++++++++++++
 tb/tb_bp_cce_ucode_loader.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_cce_pkg.sv
// Shared CCE definitions seen by the config bus, the CCE and the microcode loader.
package bp_cce_pkg;

  typedef enum logic {
    e_cce_mode_uncached = 1'b0,
    e_cce_mode_normal   = 1'b1
  } bp_cce_mode_e;

endpackage

// File: rtl/bp_cce_ucode_loader_pkg.sv
// Helpers private to the CCE microcode loader.
package bp_cce_ucode_loader_pkg;

  // A load count is usable when it is non-zero and fits in the instruction RAM.
  function automatic logic count_ok(input logic [31:0] n, input logic [31:0] depth);
    return (n != 32'd0) && (n <= depth);
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; 1-cycle update, no backpressure.
// clear_i together with up_i loads 1 so a clear can coincide with the first count.
module bsg_counter_clear_up #(
  parameter int width_p = 9
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] r_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= width_p'(up_i);
    end else if (up_i) begin
      r_count <= r_count + width_p'(1);
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/bp_cce_ucode_loader.sv
// Loads CCE microcode into instruction RAM, XOR-verifies a readback, then sets cce_mode normal.
// done_o at best 2N+5 cycles after start_i; instr_i is accepted only while in WRITE, bubbles allowed.
module bp_cce_ucode_loader
  import bp_cce_pkg::*;
  import bp_cce_ucode_loader_pkg::*;
#(
  parameter int cce_pc_width_p          = 8,
  parameter int cce_instr_width_p       = 48,
  parameter int num_cce_instr_ram_els_p = 256,
  parameter int verify_p                = 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         start_i,
  input  logic [cce_pc_width_p:0]      num_instr_i,
  input  logic                         instr_v_i,
  input  logic [cce_instr_width_p-1:0] instr_i,
  output logic                         instr_ready_o,
  output logic                         ucode_w_v_o,
  output logic                         ucode_r_v_o,
  output logic [cce_pc_width_p-1:0]    ucode_addr_o,
  output logic [cce_instr_width_p-1:0] ucode_data_o,
  input  logic [cce_instr_width_p-1:0] ucode_data_i,
  output bp_cce_mode_e                 cce_mode_o,
  output logic                         done_o,
  output logic                         error_o
);

  localparam int CNT_W = cce_pc_width_p + 1;

  typedef enum logic [2:0] {
    IDLE, WRITE, WRITE_END, READ, CHECK, MODE, DONE, ERROR
  } state_e;

  state_e                         r_state, w_state_n;
  logic [CNT_W-1:0]               r_num, w_wr_cnt, w_rd_cnt;
  logic [cce_instr_width_p-1:0]   r_wr_sum, r_rd_sum;
  logic                           r_rd_v;
  logic                           w_hs, w_clear, w_start_ok, w_rd_issue;

  logic                           r_instr_ready, r_ucode_w_v, r_ucode_r_v, r_done, r_error;
  logic [cce_pc_width_p-1:0]      r_ucode_addr;
  logic [cce_instr_width_p-1:0]   r_ucode_data;
  bp_cce_mode_e                   r_cce_mode;

  assign w_hs       = instr_v_i & r_instr_ready;
  assign w_clear    = (r_state == IDLE) & start_i;
  assign w_start_ok = count_ok(32'(num_instr_i), 32'(num_cce_instr_ram_els_p));
  // rd_cnt counts reads already issued; the bus shows each read while in READ.
  assign w_rd_issue = (verify_p != 0) &&
                      ((r_state == WRITE_END) || ((r_state == READ) && (w_rd_cnt != r_num)));

  bsg_counter_clear_up #(.width_p(CNT_W)) u_wr_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (w_clear),
    .up_i      (w_hs),
    .count_o   (w_wr_cnt)
  );

  bsg_counter_clear_up #(.width_p(CNT_W)) u_rd_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (w_clear),
    .up_i      (w_rd_issue),
    .count_o   (w_rd_cnt)
  );

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:      if (start_i) w_state_n = w_start_ok ? WRITE : ERROR;
      WRITE:     if (w_hs && (w_wr_cnt == r_num - CNT_W'(1))) w_state_n = WRITE_END;
      WRITE_END: w_state_n = (verify_p != 0) ? READ : MODE;
      READ:      if (w_rd_cnt == r_num) w_state_n = CHECK;
      // Stay while the last readback word is still in flight, then compare.
      CHECK:     if (!r_rd_v) w_state_n = (r_wr_sum == r_rd_sum) ? MODE : ERROR;
      MODE:      w_state_n = DONE;
      DONE:      w_state_n = DONE;
      ERROR:     w_state_n = ERROR;
      default:   w_state_n = ERROR;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state       <= IDLE;
      r_num         <= '0;
      r_wr_sum      <= '0;
      r_rd_sum      <= '0;
      r_rd_v        <= 1'b0;
      r_instr_ready <= 1'b0;
      r_ucode_w_v   <= 1'b0;
      r_ucode_r_v   <= 1'b0;
      r_ucode_addr  <= '0;
      r_ucode_data  <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_cce_mode    <= e_cce_mode_uncached;
    end else begin
      r_state <= w_state_n;
      if (w_clear) begin
        r_num    <= num_instr_i;
        r_wr_sum <= '0;
        r_rd_sum <= '0;
      end
      if (w_hs) r_wr_sum <= r_wr_sum ^ instr_i;
      r_rd_v <= r_ucode_r_v;
      if (r_rd_v) r_rd_sum <= r_rd_sum ^ ucode_data_i;

      r_instr_ready <= (w_state_n == WRITE);
      r_ucode_w_v   <= w_hs;
      r_ucode_r_v   <= w_rd_issue;
      r_ucode_addr  <= w_hs       ? w_wr_cnt[cce_pc_width_p-1:0] :
                       w_rd_issue ? w_rd_cnt[cce_pc_width_p-1:0] : '0;
      r_ucode_data  <= w_hs ? instr_i : '0;
      r_done        <= (w_state_n == DONE);
      r_error       <= (w_state_n == ERROR);
      r_cce_mode    <= (w_state_n == DONE) ? e_cce_mode_normal : e_cce_mode_uncached;
    end
  end

  assign instr_ready_o = r_instr_ready;
  assign ucode_w_v_o   = r_ucode_w_v;
  assign ucode_r_v_o   = r_ucode_r_v;
  assign ucode_addr_o  = r_ucode_addr;
  assign ucode_data_o  = r_ucode_data;
  assign cce_mode_o    = r_cce_mode;
  assign done_o        = r_done;
  assign error_o       = r_error;

endmodule

// File: tb/tb_bp_cce_ucode_loader.sv
// Directed bench: a verifying loader with a sync RAM model plus a non-verifying loader for the full-depth load.
module tb_bp_cce_ucode_loader;
  import bp_cce_pkg::*;

  localparam int PC_W = 8;
  localparam int IW   = 48;
  localparam int CW   = PC_W + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n_i;
  logic            start_i, instr_v_i, instr_ready_o, ucode_w_v_o, ucode_r_v_o, done_o, error_o;
  logic [CW-1:0]   num_instr_i;
  logic [IW-1:0]   instr_i, ucode_data_o, ram_q;
  logic [PC_W-1:0] ucode_addr_o;
  bp_cce_mode_e    cce_mode_o;

  logic            n_start, n_instr_v, n_instr_ready, n_w_v, n_r_v, n_done, n_error;
  logic [CW-1:0]   n_num;
  logic [IW-1:0]   n_instr, n_data_o, n_data_i;
  logic [PC_W-1:0] n_addr;
  bp_cce_mode_e    n_mode;
  assign n_data_i = '0;

  bp_cce_ucode_loader #(.cce_pc_width_p(PC_W), .cce_instr_width_p(IW),
                        .num_cce_instr_ram_els_p(256), .verify_p(1)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i), .num_instr_i(num_instr_i),
    .instr_v_i(instr_v_i), .instr_i(instr_i), .instr_ready_o(instr_ready_o),
    .ucode_w_v_o(ucode_w_v_o), .ucode_r_v_o(ucode_r_v_o), .ucode_addr_o(ucode_addr_o),
    .ucode_data_o(ucode_data_o), .ucode_data_i(ram_q), .cce_mode_o(cce_mode_o),
    .done_o(done_o), .error_o(error_o));

  bp_cce_ucode_loader #(.cce_pc_width_p(PC_W), .cce_instr_width_p(IW),
                        .num_cce_instr_ram_els_p(256), .verify_p(0)) dut_nv (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(n_start), .num_instr_i(n_num),
    .instr_v_i(n_instr_v), .instr_i(n_instr), .instr_ready_o(n_instr_ready),
    .ucode_w_v_o(n_w_v), .ucode_r_v_o(n_r_v), .ucode_addr_o(n_addr),
    .ucode_data_o(n_data_o), .ucode_data_i(n_data_i), .cce_mode_o(n_mode),
    .done_o(n_done), .error_o(n_error));

  logic [IW-1:0] mem [256];
  logic          corrupt;
  always @(posedge clk) begin
    if (ucode_w_v_o) mem[ucode_addr_o] <= ucode_data_o;
    if (ucode_r_v_o) ram_q <= mem[ucode_addr_o] ^ ((corrupt && ucode_addr_o == 8'd2) ? 48'h1 : 48'h0);
  end

  int tests, fails, cyc, c0, done_cyc, err_cyc;
  int nv_wcnt, nv_last, nv_done_cyc;
  logic [IW-1:0] nv_last_data;
  bit both_seen, nv_rv;
  int wa[$], wc[$], ra[$], rc[$];
  logic [IW-1:0] wd[$];

  task automatic clear_logs();
    wa.delete(); wc.delete(); wd.delete(); ra.delete(); rc.delete();
    done_cyc = -1; err_cyc = -1; both_seen = 0;
    nv_wcnt = 0; nv_last = -1; nv_last_data = '0; nv_rv = 0; nv_done_cyc = -1;
  endtask

  // Sample the current cycle at the falling edge, then advance to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    if (ucode_w_v_o) begin wa.push_back(int'(ucode_addr_o)); wd.push_back(ucode_data_o); wc.push_back(cyc - c0); end
    if (ucode_r_v_o) begin ra.push_back(int'(ucode_addr_o)); rc.push_back(cyc - c0); end
    if (ucode_w_v_o && ucode_r_v_o) both_seen = 1;
    if (done_o && done_cyc < 0) done_cyc = cyc - c0;
    if (error_o && err_cyc < 0) err_cyc = cyc - c0;
    if (n_w_v) begin nv_wcnt++; nv_last = int'(n_addr); nv_last_data = n_data_o; end
    if (n_r_v) nv_rv = 1;
    if (n_done && nv_done_cyc < 0) nv_done_cyc = cyc - c0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    step();
    reset_n_i = 1'b1;
    step();
  endtask

  task automatic run_load(input int n, input bit gap, input bit bad_ram, output bit to);
    logic [IW-1:0] words [4];
    int idx, g;
    bit ph, hs;
    words = '{48'h1, 48'h2, 48'h4, 48'h8};
    clear_logs();
    corrupt = bad_ram;
    c0 = cyc; start_i = 1'b1; num_instr_i = CW'(n);
    step();
    start_i = 1'b0; num_instr_i = '0;
    idx = 0; g = 0; ph = 1;
    while (idx < n && err_cyc < 0 && g < 80) begin
      instr_v_i = !gap || ph;
      instr_i   = words[idx % 4];
      hs = instr_v_i && instr_ready_o;
      step();
      if (hs) idx++;
      ph = !ph; g++;
    end
    instr_v_i = 1'b0;
    while (done_cyc < 0 && err_cyc < 0 && g < 120) begin step(); g++; end
    to = (done_cyc < 0 && err_cyc < 0);
  endtask

  task automatic test_reset();
    reset_n_i = 1'b1;
    #2 reset_n_i = 1'b0;
    #1;
    tests++; if (instr_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", instr_ready_o); end
    tests++; if (ucode_w_v_o !== 1'b0 || ucode_r_v_o !== 1'b0) begin fails++; $display("FAIL reset_valids: got w=%b r=%b expected 0 0", ucode_w_v_o, ucode_r_v_o); end
    tests++; if (ucode_addr_o !== '0 || ucode_data_o !== '0) begin fails++; $display("FAIL reset_bus: got addr=%h data=%h expected 0 0", ucode_addr_o, ucode_data_o); end
    tests++; if (done_o !== 1'b0 || error_o !== 1'b0) begin fails++; $display("FAIL reset_status: got done=%b err=%b expected 0 0", done_o, error_o); end
    tests++; if (cce_mode_o !== e_cce_mode_uncached) begin fails++; $display("FAIL reset_mode: got %0d expected %0d", cce_mode_o, e_cce_mode_uncached); end
    step(); step();
    reset_n_i = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [IW-1:0] exp_w [4];
    exp_w = '{48'h1, 48'h2, 48'h4, 48'h8};
    run_load(4, 0, 0, to);
    tests++; if (to) begin fails++; $display("FAIL b2b_timeout: got no done/error expected done"); end
    tests++; if (wa.size() != 4 || ra.size() != 4) begin fails++; $display("FAIL b2b_counts: got writes=%0d reads=%0d expected 4 4", wa.size(), ra.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < wa.size() && i < ra.size()) begin
        tests++;
        if (wa[i] != i || wd[i] !== exp_w[i] || ra[i] != i) begin
          fails++; $display("FAIL b2b_word%0d: got waddr=%0d wdata=%h raddr=%0d expected %0d %h %0d", i, wa[i], wd[i], ra[i], i, exp_w[i], i);
        end
      end
    end
    tests++; if (wc.size() != 4 || wc[0] != 2 || wc[3] != 5) begin fails++; $display("FAIL b2b_write_cycles: got first/last write cycle wrong (n=%0d) expected 2 and 5", wc.size()); end
    tests++; if (rc.size() != 4 || rc[0] != 6 || rc[3] != 9) begin fails++; $display("FAIL b2b_read_cycles: got read cycles wrong (n=%0d) expected 6..9", rc.size()); end
    tests++; if (done_cyc != 13) begin fails++; $display("FAIL b2b_done_latency: got %0d expected 13", done_cyc); end
    tests++; if (cce_mode_o !== e_cce_mode_normal) begin fails++; $display("FAIL b2b_mode: got %0d expected %0d", cce_mode_o, e_cce_mode_normal); end
    tests++; if (err_cyc != -1 || both_seen) begin fails++; $display("FAIL b2b_clean: got err_cyc=%0d both=%0d expected -1 0", err_cyc, both_seen); end
  endtask

  task automatic test_start_ignored_in_done();
    start_i = 1'b1; num_instr_i = '0;
    step();
    start_i = 1'b0;
    step(); step();
    tests++; if (done_o !== 1'b1 || error_o !== 1'b0 || instr_ready_o !== 1'b0) begin fails++; $display("FAIL done_start_ignored: got done=%b err=%b rdy=%b expected 1 0 0", done_o, error_o, instr_ready_o); end
    tests++; if (cce_mode_o !== e_cce_mode_normal) begin fails++; $display("FAIL done_mode_hold: got %0d expected %0d", cce_mode_o, e_cce_mode_normal); end
  endtask

  task automatic test_gaps();
    bit to;
    do_reset();
    run_load(4, 1, 0, to);
    tests++; if (to || done_cyc != 16) begin fails++; $display("FAIL gap_done_latency: got %0d expected 16", done_cyc); end
    tests++; if (wa.size() != 4 || wa[0] != 0 || wa[1] != 1 || wa[2] != 2 || wa[3] != 3) begin fails++; $display("FAIL gap_addrs: got %0d writes expected addrs 0..3", wa.size()); end
    tests++; if (wc.size() != 4 || wc[1] - wc[0] != 2 || wc[0] != 2) begin fails++; $display("FAIL gap_bubbles: got write cycles not at 2,4,.. (n=%0d) expected gaps of 2", wc.size()); end
    tests++; if (both_seen || err_cyc != -1) begin fails++; $display("FAIL gap_clean: got both=%0d err_cyc=%0d expected 0 -1", both_seen, err_cyc); end
  endtask

  task automatic test_corrupt();
    bit to;
    do_reset();
    run_load(4, 0, 1, to);
    corrupt = 1'b0;
    tests++; if (err_cyc != 12) begin fails++; $display("FAIL bad_sum_error_cycle: got %0d expected 12", err_cyc); end
    tests++; if (done_cyc != -1 || done_o !== 1'b0) begin fails++; $display("FAIL bad_sum_done: got done_cyc=%0d done=%b expected -1 0", done_cyc, done_o); end
    tests++; if (cce_mode_o !== e_cce_mode_uncached || error_o !== 1'b1) begin fails++; $display("FAIL bad_sum_mode: got mode=%0d err=%b expected %0d 1", cce_mode_o, error_o, e_cce_mode_uncached); end
  endtask

  task automatic test_bad_count();
    bit to;
    do_reset();
    run_load(0, 0, 0, to);
    step(); step(); step();
    tests++; if (err_cyc != 1 || wa.size() != 0) begin fails++; $display("FAIL n0_error: got err_cyc=%0d writes=%0d expected 1 0", err_cyc, wa.size()); end
    tests++; if (done_o !== 1'b0 || ucode_w_v_o !== 1'b0) begin fails++; $display("FAIL n0_quiet: got done=%b wv=%b expected 0 0", done_o, ucode_w_v_o); end
    do_reset();
    run_load(257, 0, 0, to);
    step(); step();
    tests++; if (err_cyc != 1 || wa.size() != 0 || done_o !== 1'b0) begin fails++; $display("FAIL n257_error: got err_cyc=%0d writes=%0d done=%b expected 1 0 0", err_cyc, wa.size(), done_o); end
  endtask

  task automatic test_async_reset();
    bit to;
    do_reset();
    clear_logs();
    c0 = cyc; start_i = 1'b1; num_instr_i = CW'(4);
    step();
    start_i = 1'b0; num_instr_i = '0;
    instr_v_i = 1'b1; instr_i = 48'h1;
    step();
    instr_i = 48'h2;
    step();
    instr_v_i = 1'b0;
    tests++; if (ucode_w_v_o !== 1'b1 || ucode_addr_o !== 8'd1) begin fails++; $display("FAIL arst_pre: got wv=%b addr=%0d expected 1 1", ucode_w_v_o, ucode_addr_o); end
    #2 reset_n_i = 1'b0;
    #1;
    tests++; if (ucode_w_v_o !== 1'b0 || instr_ready_o !== 1'b0) begin fails++; $display("FAIL arst_valids: got wv=%b rdy=%b expected 0 0", ucode_w_v_o, instr_ready_o); end
    tests++; if (ucode_addr_o !== '0 || ucode_data_o !== '0 || cce_mode_o !== e_cce_mode_uncached) begin fails++; $display("FAIL arst_bus: got addr=%0d data=%h mode=%0d expected 0 0 0", ucode_addr_o, ucode_data_o, cce_mode_o); end
    reset_n_i = 1'b1;
    step();
    run_load(4, 0, 0, to);
    tests++; if (to || done_cyc != 13 || err_cyc != -1) begin fails++; $display("FAIL arst_reload: got done_cyc=%0d err_cyc=%0d expected 13 -1", done_cyc, err_cyc); end
    tests++; if (wa.size() != 4 || wa[0] != 0 || wa[3] != 3) begin fails++; $display("FAIL arst_reload_addrs: got %0d writes expected addrs 0..3", wa.size()); end
  endtask

  task automatic test_no_verify();
    int idx, g;
    bit hs;
    do_reset();
    clear_logs();
    c0 = cyc; n_start = 1'b1; n_num = CW'(256);
    step();
    n_start = 1'b0; n_num = '0;
    idx = 0; g = 0;
    while (idx < 256 && g < 400) begin
      n_instr_v = 1'b1;
      n_instr   = IW'(idx + 1);
      hs = n_instr_ready;
      step();
      if (hs) idx++;
      g++;
    end
    n_instr_v = 1'b0;
    while (nv_done_cyc < 0 && g < 450) begin step(); g++; end
    tests++; if (nv_done_cyc != 259) begin fails++; $display("FAIL nv_done_latency: got %0d expected 259", nv_done_cyc); end
    tests++; if (nv_wcnt != 256 || nv_last != 255 || nv_last_data !== 48'h100) begin fails++; $display("FAIL nv_writes: got count=%0d last_addr=%0d last_data=%h expected 256 255 100", nv_wcnt, nv_last, nv_last_data); end
    tests++; if (nv_rv) begin fails++; $display("FAIL nv_no_reads: got read valid seen expected none"); end
    tests++; if (n_mode !== e_cce_mode_normal || n_error !== 1'b0) begin fails++; $display("FAIL nv_mode: got mode=%0d err=%b expected %0d 0", n_mode, n_error, e_cce_mode_normal); end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; c0 = 0;
    start_i = 1'b0; num_instr_i = '0; instr_v_i = 1'b0; instr_i = '0; corrupt = 1'b0;
    n_start = 1'b0; n_num = '0; n_instr_v = 1'b0; n_instr = '0;
    clear_logs();
    test_reset();
    test_back_to_back();
    test_start_ignored_in_done();
    test_gaps();
    test_corrupt();
    test_bad_count();
    test_async_reset();
    test_no_verify();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
